// File: rtl/board_fsm.sv
// N x N tic-tac-toe board controller with a synchronized move button
// and combinational pixel-to-cell lookup for the display path.
module board_fsm #(
  parameter int N    = 3,
  parameter int CELL = 128,
  parameter int GAP  = 16,
  parameter int X0   = 112,
  parameter int Y0   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             button,
  input  logic [N*N-1:0]   switches,
  input  logic [9:0]       x,
  input  logic [9:0]       y,
  output logic [2*N*N-1:0] board,
  output logic             turn,
  output logic [1:0]       state,
  output logic [1:0]       winner,
  output logic             err,
  output logic             square,
  output logic             highlight,
  output logic [1:0]       mark
);

  localparam int NC    = N * N;
  localparam int PITCH = CELL + GAP;

  typedef enum logic [1:0] {
    S_PLAY  = 2'b00,
    S_CHECK = 2'b01,
    S_WIN   = 2'b10,
    S_DRAW  = 2'b11
  } state_e;

  logic            sync1_q, sync2_q, hist_q;
  logic [1:0]      vld_q, vld_d;
  logic            armed_q, armed_d;
  logic [2*NC-1:0] board_q, board_d;
  logic            turn_q, turn_d;
  state_e          state_q, state_d;
  logic [1:0]      winner_q, winner_d;
  logic            err_q, err_d;

  logic press;
  logic sel_busy;
  logic legal;
  logic win;
  logic full;

  function automatic logic [1:0] cell_at(
    input logic [2*NC-1:0] b,
    input int              i
  );
    return b[2*i +: 2];
  endfunction

  // A button held through reset must be seen low once before it counts.
  always_comb begin
    vld_d   = {vld_q[0], 1'b1};
    armed_d = armed_q | (vld_q[1] & ~sync2_q);
  end

  assign press = sync2_q & ~hist_q & armed_q;

  always_comb begin
    sel_busy = 1'b0;
    for (int i = 0; i < NC; i++) begin
      if (switches[i] && cell_at(board_q, i) != 2'b00)
        sel_busy = 1'b1;
    end
  end

  assign legal = $onehot(switches) && !sel_busy;

  always_comb begin : p_lines
    logic ln;
    win  = 1'b0;
    full = 1'b1;
    ln   = 1'b0;
    for (int i = 0; i < NC; i++) begin
      if (cell_at(board_q, i) == 2'b00)
        full = 1'b0;
    end
    for (int r = 0; r < N; r++) begin
      ln = cell_at(board_q, r*N) != 2'b00;
      for (int c = 1; c < N; c++) begin
        if (cell_at(board_q, r*N+c) != cell_at(board_q, r*N))
          ln = 1'b0;
      end
      win = win | ln;
    end
    for (int c = 0; c < N; c++) begin
      ln = cell_at(board_q, c) != 2'b00;
      for (int r = 1; r < N; r++) begin
        if (cell_at(board_q, r*N+c) != cell_at(board_q, c))
          ln = 1'b0;
      end
      win = win | ln;
    end
    ln = cell_at(board_q, 0) != 2'b00;
    for (int i = 1; i < N; i++) begin
      if (cell_at(board_q, i*N+i) != cell_at(board_q, 0))
        ln = 1'b0;
    end
    win = win | ln;
    ln = cell_at(board_q, N-1) != 2'b00;
    for (int i = 1; i < N; i++) begin
      if (cell_at(board_q, i*N+N-1-i) != cell_at(board_q, N-1))
        ln = 1'b0;
    end
    win = win | ln;
  end

  always_comb begin
    board_d  = board_q;
    turn_d   = turn_q;
    state_d  = state_q;
    winner_d = winner_q;
    err_d    = 1'b0;
    unique case (state_q)
      S_PLAY: begin
        if (press) begin
          if (legal) begin
            for (int i = 0; i < NC; i++) begin
              if (switches[i])
                board_d[2*i +: 2] = {turn_q, ~turn_q};
            end
            state_d = S_CHECK;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_CHECK: begin
        if (win) begin
          state_d  = S_WIN;
          winner_d = {turn_q, ~turn_q};
        end else if (full) begin
          state_d  = S_DRAW;
          winner_d = 2'b00;
        end else begin
          turn_d  = ~turn_q;
          state_d = S_PLAY;
        end
      end
      S_WIN, S_DRAW: begin
        if (press) begin
          board_d  = '0;
          winner_d = 2'b00;
          turn_d   = 1'b0;
          state_d  = S_PLAY;
        end
      end
      default: state_d = S_PLAY;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      hist_q   <= 1'b0;
      vld_q    <= 2'b00;
      armed_q  <= 1'b0;
      board_q  <= '0;
      turn_q   <= 1'b0;
      state_q  <= S_PLAY;
      winner_q <= 2'b00;
      err_q    <= 1'b0;
    end else begin
      sync1_q  <= button;
      sync2_q  <= sync1_q;
      hist_q   <= sync2_q;
      vld_q    <= vld_d;
      armed_q  <= armed_d;
      board_q  <= board_d;
      turn_q   <= turn_d;
      state_q  <= state_d;
      winner_q <= winner_d;
      err_q    <= err_d;
    end
  end

  assign board  = board_q;
  assign turn   = turn_q;
  assign state  = state_q;
  assign winner = winner_q;
  assign err    = err_q;

  // 12-bit geometry keeps X0 + N*PITCH from wrapping.
  logic [11:0] xe, ye;
  logic [N-1:0] in_col, in_row;

  always_comb begin
    xe = {2'b00, x};
    ye = {2'b00, y};
    for (int k = 0; k < N; k++) begin
      in_col[k] = (xe >= 12'(X0 + k*PITCH)) &&
                  (xe <  12'(X0 + k*PITCH + CELL));
      in_row[k] = (ye >= 12'(Y0 + k*PITCH)) &&
                  (ye <  12'(Y0 + k*PITCH + CELL));
    end
  end

  always_comb begin
    square    = 1'b0;
    highlight = 1'b0;
    mark      = 2'b00;
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        if (in_row[r] && in_col[c]) begin
          square    = 1'b1;
          highlight = switches[r*N+c];
          mark      = cell_at(board_q, r*N+c);
        end
      end
    end
  end

endmodule

// File: tb/tb_board_fsm.sv
// Bench for board_fsm: table-driven game moves through a scoreboard
// queue, plus reset, held-button and geometry sequences.
module tb_board_fsm;

  localparam logic [1:0] PLAY = 2'b00;
  localparam logic [1:0] CHK  = 2'b01;
  localparam logic [1:0] WIN  = 2'b10;
  localparam logic [1:0] DRAW = 2'b11;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        button = 1'b0;
  logic [8:0]  switches = '0;
  logic [9:0]  x = '0;
  logic [9:0]  y = '0;
  logic [17:0] board;
  logic        turn;
  logic [1:0]  state;
  logic [1:0]  winner;
  logic        err;
  logic        square;
  logic        highlight;
  logic [1:0]  mark;

  int n_cmp = 0;
  int n_bad = 0;

  board_fsm dut (
    .clk(clk), .rst(rst), .button(button),
    .switches(switches), .x(x), .y(y),
    .board(board), .turn(turn), .state(state),
    .winner(winner), .err(err), .square(square),
    .highlight(highlight), .mark(mark)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [8:0]  sw;
    logic [1:0]  mid;
    logic        rej;
    logic [1:0]  st;
    logic [1:0]  win;
    logic        trn;
    logic [17:0] brd;
  } vec_t;

  typedef struct {
    logic [9:0] gx;
    logic [9:0] gy;
    logic [8:0] sw;
    logic       sq;
    logic       hl;
    logic [1:0] mk;
  } geo_t;

  vec_t tbl[$];
  vec_t sb[$];
  geo_t geo[$];

  function automatic vec_t mk(
    input string nm, input logic [8:0] sw, input logic [1:0] mid,
    input logic rej, input logic [1:0] st, input logic [1:0] w,
    input logic t, input logic [17:0] b
  );
    vec_t v;
    v.name = nm; v.sw = sw; v.mid = mid; v.rej = rej;
    v.st = st; v.win = w; v.trn = t; v.brd = b;
    return v;
  endfunction

  function automatic geo_t mg(
    input logic [9:0] gx, input logic [9:0] gy, input logic [8:0] sw,
    input logic sq, input logic hl, input logic [1:0] m
  );
    geo_t g;
    g.gx = gx; g.gy = gy; g.sw = sw; g.sq = sq; g.hl = hl; g.mk = m;
    return g;
  endfunction

  task automatic chk(input string nm, input logic [17:0] act,
                     input logic [17:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Press with the given switches; sample one cycle after the action
  // edge and again after the CHECK cycle.
  task automatic apply(input vec_t v);
    vec_t       e;
    logic [1:0] mid_s;
    logic       err_s;
    @(posedge clk); #1;
    switches = v.sw;
    button   = 1'b1;
    sb.push_back(v);
    repeat (3) @(posedge clk);
    #1;
    mid_s = state;
    err_s = err;
    @(posedge clk); #1;
    e = sb.pop_front();
    chk({e.name, " mid_state"}, 18'(mid_s), 18'(e.mid));
    chk({e.name, " err_pulse"}, 18'(err_s), 18'(e.rej));
    chk({e.name, " err_after"}, 18'(err), 18'(0));
    chk({e.name, " state"}, 18'(state), 18'(e.st));
    chk({e.name, " winner"}, 18'(winner), 18'(e.win));
    chk({e.name, " turn"}, 18'(turn), 18'(e.trn));
    chk({e.name, " board"}, board, e.brd);
    button = 1'b0;
    repeat (4) @(posedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: sim time exceeded");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl.push_back(mk("g1 X0", 9'h001, CHK, 0, PLAY, 2'b00, 1, 18'h00001));
    tbl.push_back(mk("occupied", 9'h001, PLAY, 1, PLAY, 2'b00, 1, 18'h00001));
    tbl.push_back(mk("multihot", 9'h003, PLAY, 1, PLAY, 2'b00, 1, 18'h00001));
    tbl.push_back(mk("zero sw", 9'h000, PLAY, 1, PLAY, 2'b00, 1, 18'h00001));
    tbl.push_back(mk("g1 O3", 9'h008, CHK, 0, PLAY, 2'b00, 0, 18'h00081));
    tbl.push_back(mk("g1 X1", 9'h002, CHK, 0, PLAY, 2'b00, 1, 18'h00085));
    tbl.push_back(mk("g1 O4", 9'h010, CHK, 0, PLAY, 2'b00, 0, 18'h00285));
    tbl.push_back(mk("g1 X2 win", 9'h004, CHK, 0, WIN, 2'b01, 0, 18'h00295));
    tbl.push_back(mk("new after win", 9'h1FF, PLAY, 0, PLAY, 2'b00, 0, 18'h0));
    tbl.push_back(mk("g2 X0", 9'h001, CHK, 0, PLAY, 2'b00, 1, 18'h00001));
    tbl.push_back(mk("g2 O2", 9'h004, CHK, 0, PLAY, 2'b00, 0, 18'h00021));
    tbl.push_back(mk("g2 X1", 9'h002, CHK, 0, PLAY, 2'b00, 1, 18'h00025));
    tbl.push_back(mk("g2 O3", 9'h008, CHK, 0, PLAY, 2'b00, 0, 18'h000A5));
    tbl.push_back(mk("g2 X5", 9'h020, CHK, 0, PLAY, 2'b00, 1, 18'h004A5));
    tbl.push_back(mk("g2 O4", 9'h010, CHK, 0, PLAY, 2'b00, 0, 18'h006A5));
    tbl.push_back(mk("g2 X6", 9'h040, CHK, 0, PLAY, 2'b00, 1, 18'h016A5));
    tbl.push_back(mk("g2 O7", 9'h080, CHK, 0, PLAY, 2'b00, 0, 18'h096A5));
    tbl.push_back(mk("g2 X8 draw", 9'h100, CHK, 0, DRAW, 2'b00, 0, 18'h196A5));
    tbl.push_back(mk("new after draw", 9'h000, PLAY, 0, PLAY, 2'b00, 0, 18'h0));

    geo.push_back(mg(10'd240, 10'd32,  9'h001, 0, 0, 2'b00));
    geo.push_back(mg(10'd239, 10'd159, 9'h001, 1, 1, 2'b01));
    geo.push_back(mg(10'd112, 10'd32,  9'h001, 1, 1, 2'b01));
    geo.push_back(mg(10'd111, 10'd32,  9'h001, 0, 0, 2'b00));
    geo.push_back(mg(10'd239, 10'd160, 9'h001, 0, 0, 2'b00));
    geo.push_back(mg(10'd256, 10'd32,  9'h001, 1, 0, 2'b00));
    geo.push_back(mg(10'd239, 10'd159, 9'h000, 1, 0, 2'b01));
    geo.push_back(mg(10'd400, 10'd320, 9'h100, 1, 1, 2'b00));

    // reset state, checked while reset is held
    repeat (3) @(posedge clk);
    #1;
    chk("rst board", board, 18'h0);
    chk("rst turn", 18'(turn), 18'(0));
    chk("rst state", 18'(state), 18'(PLAY));
    chk("rst winner", 18'(winner), 18'(0));
    chk("rst err", 18'(err), 18'(0));

    // button held through reset release must not register a press
    switches = 9'h001;
    button   = 1'b1;
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("held state", 18'(state), 18'(PLAY));
    chk("held board", board, 18'h0);
    chk("held err", 18'(err), 18'(0));
    button = 1'b0;
    repeat (5) @(posedge clk);

    for (int i = 0; i < tbl.size(); i++)
      apply(tbl[i]);

    apply(mk("geo X0", 9'h001, CHK, 0, PLAY, 2'b00, 1, 18'h00001));
    for (int i = 0; i < geo.size(); i++) begin
      x = geo[i].gx;
      y = geo[i].gy;
      switches = geo[i].sw;
      #1;
      chk($sformatf("geo%0d square", i), 18'(square), 18'(geo[i].sq));
      chk($sformatf("geo%0d highlight", i), 18'(highlight), 18'(geo[i].hl));
      chk($sformatf("geo%0d mark", i), 18'(mark), 18'(geo[i].mk));
    end

    // reset asserted while the winning move is in CHECK
    apply(mk("g3 O3", 9'h008, CHK, 0, PLAY, 2'b00, 0, 18'h00081));
    apply(mk("g3 X1", 9'h002, CHK, 0, PLAY, 2'b00, 1, 18'h00085));
    apply(mk("g3 O4", 9'h010, CHK, 0, PLAY, 2'b00, 0, 18'h00285));
    @(posedge clk); #1;
    switches = 9'h004;
    button   = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("g3 in check", 18'(state), 18'(CHK));
    rst = 1'b0;
    #1;
    chk("midrst board", board, 18'h0);
    chk("midrst turn", 18'(turn), 18'(0));
    chk("midrst state", 18'(state), 18'(PLAY));
    chk("midrst winner", 18'(winner), 18'(0));
    button = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("postrst state", 18'(state), 18'(PLAY));
    chk("postrst winner", 18'(winner), 18'(0));
    chk("postrst board", board, 18'h0);

    apply(mk("post X4", 9'h010, CHK, 0, PLAY, 2'b00, 1, 18'h00100));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/board_fsm.md
BOARD_FSM -- requirements
Module: board_fsm

Interface
REQ-001 SHALL have parameter N, default 3, board dimension (N x N cells, legal 3..8).
REQ-002 SHALL have parameter CELL, default 128, cell edge in pixels.
REQ-003 SHALL have parameter GAP, default 16, pixels between adjacent cells.
REQ-004 SHALL have parameter X0, default 112, left pixel of column 0.
REQ-005 SHALL have parameter Y0, default 32, top pixel of row 0.
REQ-006 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-007 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-008 SHALL have port button  input  1  raw move/new-game button, asynchronous to clk.
REQ-009 SHALL have port switches  input  N*N  cell select, bit i = cell i (row i/N, col i%N).
REQ-010 SHALL have port x  input  10  current pixel column.
REQ-011 SHALL have port y  input  10  current pixel row.
REQ-012 SHALL have port board  output  2*N*N  registered cell contents, bits [2i+1:2i] = cell i: 00 empty, 01 X, 10 O.
REQ-013 SHALL have port turn  output  1  player to move: 0 X, 1 O.
REQ-014 SHALL have port state  output  2  00 PLAY, 01 CHECK, 10 WIN, 11 DRAW.
REQ-015 SHALL have port winner  output  2  01 X, 10 O, 00 none.
REQ-016 SHALL have port err  output  1  one-cycle pulse on a rejected move.
REQ-017 SHALL have port square  output  1  pixel inside any cell.
REQ-018 SHALL have port highlight  output  1  pixel inside a cell whose switch is set.
REQ-019 SHALL have port mark  output  2  contents of the cell under the pixel, 00 outside all cells.

Function
REQ-020 SHALL pass button through two synchronizer flops plus one history flop; press = sync2 & ~hist, one cycle per rising edge.
REQ-021 SHALL, in PLAY on press with switches one-hot and the selected cell empty, write {turn, ~turn} to that cell on the next edge and enter CHECK.
REQ-022 SHALL, in PLAY on press with switches zero, multi-hot or selecting an occupied cell, leave board/turn/state unchanged and pulse err for exactly the following cycle.
REQ-023 SHALL, in CHECK, evaluate all N rows, N columns and both diagonals for N identical non-empty cells; win -> WIN with winner = the writing player.
REQ-024 SHALL, in CHECK with no win and all cells non-empty, enter DRAW with winner 00; win takes priority over full board.
REQ-025 SHALL, in CHECK with no win and no full board, toggle turn and return to PLAY; CHECK always lasts exactly one cycle.
REQ-026 SHALL, in WIN or DRAW on press, clear board, set winner 00, turn 0 and enter PLAY on the next edge, independent of switches; err SHALL stay 0.
REQ-027 SHALL ignore presses while in CHECK; no press is queued.
REQ-028 SHALL define cell (r,c) as x in [X0+c*(CELL+GAP), X0+c*(CELL+GAP)+CELL) and y in [Y0+r*(CELL+GAP), Y0+r*(CELL+GAP)+CELL), half-open.
REQ-029 SHALL compute square, highlight and mark combinationally from x, y, switches and the registered board, with no clock latency.
REQ-030 SHALL use at least 11-bit intermediates for geometry so X0+N*(CELL+GAP) cannot wrap.

Reset
REQ-031 SHALL, while rst=0, asynchronously force board all 00, turn 0, state PLAY, winner 00, err 0 and synchronizer/history flops 0.
REQ-032 SHALL, on reset asserted mid-CHECK, discard the pending evaluation; the written move is cleared with the board.
REQ-033 SHALL NOT detect a press from a button already held high when rst releases until the button is released and pressed again.

Verification
REQ-034 SHALL cover: N=3, X plays 0,3,1,4,2 (O at 3,4) -> after last CHECK state=10, winner=01, board[5:0]=010101.
REQ-035 SHALL cover: press with switches=9'h001 on occupied cell 0 -> err=1 for one cycle, board and turn unchanged.
REQ-036 SHALL cover: switches=9'h003 press -> err pulse, state stays 00.
REQ-037 SHALL cover: full board without a line (X:0,1,5,6,8; O:2,3,4,7) -> state=11, winner=00.
REQ-038 SHALL cover: rst low during CHECK -> board=0, turn=0, state=00 immediately, no WIN entered.
REQ-039 SHALL cover: x=240,y=32 -> square=0; x=239,y=159 with cell 0 = X and switches[0]=1 -> square=1, highlight=1, mark=01.
